dram_req_seq: RTL and testbench

//  Downstream of the bus arbiter. Takes the arbitrated DRAM request (addr, wdata, le/we_t pulse,

---
 rtl/dram_req_seq_pkg.sv | 41 ++++
 rtl/dram_req_seq_if.sv | 29 ++
 rtl/dram_req_seq_lane_align.sv | 37 +++
 rtl/dram_req_seq.sv | 163 ++++++++++++++++
 tb/tb_dram_req_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/dram_req_seq_pkg.sv
// Shared types and helpers for the DRAM request sequencer: FSM state
// encoding, funct3 access-size codes, byte-mask and load-extension helpers.
package dram_req_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ0 = 2'd1,
    ST_REQ1 = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unshifted byte mask for an access size; unknown codes behave as a word.
  function automatic logic [3:0] size_mask(input logic [2:0] ctrl);
    logic [3:0] m;
    case (ctrl)
      F3_B, F3_BU: m = 4'b0001;
      F3_H, F3_HU: m = 4'b0011;
      default:     m = 4'b1111;
    endcase
    return m;
  endfunction

  // Sign- or zero-extend LSB-aligned load data according to funct3.
  function automatic logic [31:0] extend_load(input logic [2:0] ctrl, input logic [31:0] raw);
    logic [31:0] v;
    case (ctrl)
      F3_B:    v = {{24{raw[7]}}, raw[7:0]};
      F3_H:    v = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   v = {24'h000000, raw[7:0]};
      F3_HU:   v = {16'h0000, raw[15:0]};
      default: v = raw;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dram_req_seq_if.sv
// Bundle of the arbiter-side request port and the memory-controller beat
// port. master = the sequencer, slave = arbiter/controller environment.
interface dram_req_seq_if;
  logic [31:0] w_dram_addr;
  logic [31:0] w_dram_wdata;
  logic        w_dram_le;
  logic        w_dram_we_t;
  logic [2:0]  w_dram_ctrl;
  logic [31:0] w_dram_odata;
  logic        w_dram_busy;
  logic        mc_req;
  logic        mc_we;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic [3:0]  mc_be;
  logic        mc_ack;
  logic [31:0] mc_rdata;
  logic        err_timeout;

  modport master (
    input  w_dram_addr, w_dram_wdata, w_dram_le, w_dram_we_t, w_dram_ctrl, mc_ack, mc_rdata,
    output w_dram_odata, w_dram_busy, mc_req, mc_we, mc_addr, mc_wdata, mc_be, err_timeout
  );

  modport slave (
    output w_dram_addr, w_dram_wdata, w_dram_le, w_dram_we_t, w_dram_ctrl, mc_ack, mc_rdata,
    input  w_dram_odata, w_dram_busy, mc_req, mc_we, mc_addr, mc_wdata, mc_be, err_timeout
  );
endinterface

// File: rtl/dram_req_seq_lane_align.sv
// dram_lane_align: purely combinational lane logic. Builds the 8-bit byte
// mask across the two candidate beats, positions store data into lanes and
// merges/extends the two read words back into an LSB-aligned load result.
module dram_lane_align (
  input  logic [1:0]  offset,
  input  logic [2:0]  ctrl,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic        split,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] ldata
);
  import dram_req_seq_pkg::*;

  logic [7:0]  mask_s;
  logic [63:0] wide_s;
  logic [31:0] raw_s;
  logic [5:0]  shift_s;

  // Mask, lane shift and read merge for the current access.
  always_comb begin
    shift_s = {offset, 3'b000};
    mask_s  = {4'b0000, size_mask(ctrl)} << offset;
    wide_s  = {32'h00000000, wdata} << shift_s;
    raw_s   = 32'({rdata1, rdata0} >> shift_s);
    split   = |mask_s[7:4];
    be0     = mask_s[3:0];
    be1     = mask_s[7:4];
    wdata0  = wide_s[31:0];
    wdata1  = wide_s[63:32];
    ldata   = extend_load(ctrl, raw_s);
  end
endmodule

// File: rtl/dram_req_seq.sv
// dram_req_seq: sequences one arbitrated load/store onto the memory
// controller req/ack port, splitting misaligned accesses into two word
// beats. Optional abort-on-timeout is enabled by defining DRAM_SEQ_TIMEOUT_EN.
module dram_req_seq #(
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input logic           CLK,
  input logic           RST_X,
  dram_req_seq_if.master bus
);
  import dram_req_seq_pkg::*;

  seq_state_t  state_r, state_next;
  logic [1:0]  offset_r;
  logic [31:0] wdata_r, rdata0_r, rdata1_r;
  logic [2:0]  ctrl_r;
  logic        we_r;
  logic        mc_req_r, mc_we_r, err_r;
  logic [31:0] mc_addr_r, mc_wdata_r, odata_r;
  logic [3:0]  mc_be_r;

  logic        trigger_s, beat_done_s, abort_s, idle_s;
  logic [1:0]  sel_offset_s;
  logic [2:0]  sel_ctrl_s;
  logic [31:0] sel_wdata_s;
  logic        split_s;
  logic [3:0]  be0_s, be1_s;
  logic [31:0] wdata0_s, wdata1_s, ldata_s;

  assign idle_s      = (state_r == ST_IDLE);
  assign trigger_s   = bus.w_dram_le | bus.w_dram_we_t;
  assign beat_done_s = mc_req_r & bus.mc_ack;

  // In IDLE the lane logic looks at the live request so beat 0 can be
  // registered on the trigger edge; afterwards it works on latched values.
  assign sel_offset_s = idle_s ? bus.w_dram_addr[1:0] : offset_r;
  assign sel_ctrl_s   = idle_s ? bus.w_dram_ctrl      : ctrl_r;
  assign sel_wdata_s  = idle_s ? bus.w_dram_wdata     : wdata_r;

  dram_lane_align u_align (
    .offset (sel_offset_s),
    .ctrl   (sel_ctrl_s),
    .wdata  (sel_wdata_s),
    .rdata0 (rdata0_r),
    .rdata1 (rdata1_r),
    .split  (split_s),
    .be0    (be0_s),
    .be1    (be1_s),
    .wdata0 (wdata0_s),
    .wdata1 (wdata1_s),
    .ldata  (ldata_s)
  );

`ifdef DRAM_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_r;

  assign abort_s = mc_req_r & ~bus.mc_ack & (tmo_cnt_r == CNT_W'(TIMEOUT_CYC - 1));

  // Wait-cycle counter: restarts on every state change, counts unacked request cycles.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (state_next != state_r) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (mc_req_r & ~bus.mc_ack) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end
  end
`else
  // No timeout hardware: the sequencer waits for the ack indefinitely.
  assign abort_s = 1'b0 & (TIMEOUT_CYC > 0);
`endif

  // Next-state logic for the beat sequencer.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: if (trigger_s)        state_next = ST_REQ0;   else state_next = ST_IDLE;
      ST_REQ0: if (abort_s)          state_next = ST_IDLE;
               else if (beat_done_s) state_next = split_s ? ST_REQ1 : ST_DONE;
               else                  state_next = ST_REQ0;
      ST_REQ1: if (abort_s)          state_next = ST_IDLE;
               else if (beat_done_s) state_next = ST_DONE;
               else                  state_next = ST_REQ1;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state_r <= ST_IDLE;
    else        state_r <= state_next;
  end

  // Request latch, beat outputs, read capture and load result register.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      offset_r   <= 2'b00;
      wdata_r    <= 32'h00000000;
      ctrl_r     <= 3'b000;
      we_r       <= 1'b0;
      rdata0_r   <= 32'h00000000;
      rdata1_r   <= 32'h00000000;
      mc_req_r   <= 1'b0;
      mc_we_r    <= 1'b0;
      mc_addr_r  <= 32'h00000000;
      mc_wdata_r <= 32'h00000000;
      mc_be_r    <= 4'b0000;
      odata_r    <= 32'h00000000;
      err_r      <= 1'b0;
    end else begin
      err_r <= abort_s;
      if (abort_s) begin
        mc_req_r <= 1'b0;
        if (!we_r) odata_r <= ERR_DATA;
      end else begin
        case (state_r)
          ST_IDLE: if (trigger_s) begin
            // Store wins when both triggers arrive together.
            offset_r   <= bus.w_dram_addr[1:0];
            wdata_r    <= bus.w_dram_wdata;
            ctrl_r     <= bus.w_dram_ctrl;
            we_r       <= bus.w_dram_we_t;
            mc_req_r   <= 1'b1;
            mc_we_r    <= bus.w_dram_we_t;
            mc_addr_r  <= {bus.w_dram_addr[31:2], 2'b00};
            mc_be_r    <= be0_s;
            mc_wdata_r <= wdata0_s;
          end
          ST_REQ0: if (beat_done_s) begin
            rdata0_r <= bus.mc_rdata;
            if (split_s) begin
              // Second beat follows immediately; address wraps mod 2^32.
              mc_addr_r  <= mc_addr_r + 32'd4;
              mc_be_r    <= be1_s;
              mc_wdata_r <= wdata1_s;
            end else begin
              mc_req_r <= 1'b0;
            end
          end
          ST_REQ1: if (beat_done_s) begin
            rdata1_r <= bus.mc_rdata;
            mc_req_r <= 1'b0;
          end
          ST_DONE: if (!we_r) odata_r <= ldata_s;
          default: ;
        endcase
      end
    end
  end

  assign bus.w_dram_busy  = ~idle_s | trigger_s;
  assign bus.w_dram_odata = odata_r;
  assign bus.mc_req       = mc_req_r;
  assign bus.mc_we        = mc_we_r;
  assign bus.mc_addr      = mc_addr_r;
  assign bus.mc_wdata     = mc_wdata_r;
  assign bus.mc_be        = mc_be_r;
  assign bus.err_timeout  = err_r;
endmodule

// File: tb/tb_dram_req_seq.sv
// Self-checking bench for dram_req_seq: directed and randomized loads/stores
// checked against a byte-level reference model of beats and load results.
module tb_dram_req_seq;
  localparam int TMO = 8;

  logic CLK = 1'b0;
  logic RST_X = 1'b0;
  always #5 CLK = ~CLK;

  dram_req_seq_if bus_if();

  dram_req_seq #(.TIMEOUT_CYC(TMO), .ERR_DATA(32'hDEADBEEF)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus_if)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_odata = 32'h0;

  function automatic int size_of(input logic [2:0] c);
    case (c)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Gather the n accessed bytes from the two read words, then extend.
  function automatic logic [31:0] exp_load(input logic [2:0] c, input int o,
                                           input logic [31:0] r0, input logic [31:0] r1);
    logic [63:0] w;
    logic [31:0] v;
    int n;
    w = {r1, r0};
    n = size_of(c);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(o+i) +: 8];
    if ((c == 3'b000 || c == 3'b001) && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input int o, input int n, input int k);
    logic [3:0] b;
    for (int j = 0; j < 4; j++) b[j] = ((4*k + j) >= o) && ((4*k + j) < (o + n));
    return b;
  endfunction

  function automatic logic [31:0] exp_wd(input int o, input logic [31:0] wd, input int k);
    logic [31:0] d;
    int p;
    d = 32'h0;
    for (int j = 0; j < 4; j++) begin
      p = 4*k + j - o;
      if (p >= 0 && p < 4) d[8*j +: 8] = wd[8*p +: 8];
    end
    return d;
  endfunction

  task automatic do_txn(input bit ld, input bit st, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] r0, input logic [31:0] r1,
                        input int d0, input int d1, input bit extra_le);
    int o, n, nb, lat, d, guard, exp_lat;
    logic [31:0] ea;
    o  = int'(a[1:0]);
    n  = size_of(c);
    nb = (o + n > 4) ? 2 : 1;
    @(negedge CLK);
    bus_if.w_dram_addr = a; bus_if.w_dram_wdata = wd; bus_if.w_dram_ctrl = c;
    bus_if.w_dram_le = ld; bus_if.w_dram_we_t = st;
    #1;
    checks++; if (bus_if.w_dram_busy !== 1'b1) begin errors++; $display("FAIL busy_trigger: got %b exp 1", bus_if.w_dram_busy); end
    @(negedge CLK);
    bus_if.w_dram_le = 1'b0; bus_if.w_dram_we_t = 1'b0;
    bus_if.w_dram_addr = $urandom; bus_if.w_dram_wdata = $urandom; bus_if.w_dram_ctrl = 3'($urandom_range(0, 7));
    lat = 1;
    for (int k = 0; k < nb; k++) begin
      ea = (a & 32'hFFFFFFFC) + 32'(4*k);
      checks++; if (bus_if.mc_req !== 1'b1) begin errors++; $display("FAIL beat%0d_req: got %b exp 1", k, bus_if.mc_req); end
      checks++; if (bus_if.mc_addr !== ea) begin errors++; $display("FAIL beat%0d_addr: got %h exp %h", k, bus_if.mc_addr, ea); end
      checks++; if (bus_if.mc_be !== exp_be(o, n, k)) begin errors++; $display("FAIL beat%0d_be: got %b exp %b", k, bus_if.mc_be, exp_be(o, n, k)); end
      checks++; if (bus_if.mc_we !== st) begin errors++; $display("FAIL beat%0d_we: got %b exp %b", k, bus_if.mc_we, st); end
      if (st) begin
        checks++; if (bus_if.mc_wdata !== exp_wd(o, wd, k)) begin errors++; $display("FAIL beat%0d_wdata: got %h exp %h", k, bus_if.mc_wdata, exp_wd(o, wd, k)); end
      end
      if (extra_le && k == 0) begin
        bus_if.w_dram_le = 1'b1;
        @(negedge CLK); lat++;
        bus_if.w_dram_le = 1'b0;
      end
      d = (k == 0) ? d0 : d1;
      repeat (d) begin @(negedge CLK); lat++; end
      checks++; if (bus_if.mc_req !== 1'b1 || bus_if.mc_addr !== ea) begin errors++; $display("FAIL beat%0d_hold: req %b addr %h exp 1 %h", k, bus_if.mc_req, bus_if.mc_addr, ea); end
      bus_if.mc_ack = 1'b1; bus_if.mc_rdata = (k == 0) ? r0 : r1;
      @(negedge CLK); lat++;
      bus_if.mc_ack = 1'b0; bus_if.mc_rdata = $urandom;
    end
    checks++; if (bus_if.mc_req !== 1'b0) begin errors++; $display("FAIL req_drop: got %b exp 0", bus_if.mc_req); end
    guard = 0;
    while (bus_if.w_dram_busy !== 1'b0 && guard < 20) begin @(negedge CLK); lat++; guard++; end
    exp_lat = 2 + nb + d0 + ((nb > 1) ? d1 : 0) + (extra_le ? 1 : 0);
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL latency: got %0d exp %0d", lat, exp_lat); end
    if (!st) exp_odata = exp_load(c, o, r0, r1);
    checks++; if (bus_if.w_dram_odata !== exp_odata) begin errors++; $display("FAIL odata: got %h exp %h", bus_if.w_dram_odata, exp_odata); end
    checks++; if (bus_if.err_timeout !== 1'b0) begin errors++; $display("FAIL err_idle: got %b exp 0", bus_if.err_timeout); end
  endtask

  task automatic test_reset();
    RST_X = 1'b0;
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
    @(negedge CLK);
    checks++; if (bus_if.mc_req !== 1'b0 || bus_if.mc_we !== 1'b0) begin errors++; $display("FAIL rst_req_we: got %b%b exp 00", bus_if.mc_req, bus_if.mc_we); end
    checks++; if (bus_if.mc_addr !== 32'h0 || bus_if.mc_wdata !== 32'h0) begin errors++; $display("FAIL rst_addr_wdata: got %h %h exp 0 0", bus_if.mc_addr, bus_if.mc_wdata); end
    checks++; if (bus_if.mc_be !== 4'b0000) begin errors++; $display("FAIL rst_be: got %b exp 0000", bus_if.mc_be); end
    checks++; if (bus_if.w_dram_odata !== 32'h0 || bus_if.err_timeout !== 1'b0) begin errors++; $display("FAIL rst_odata_err: got %h %b exp 0 0", bus_if.w_dram_odata, bus_if.err_timeout); end
    checks++; if (bus_if.w_dram_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", bus_if.w_dram_busy); end
  endtask

  task automatic test_directed();
    do_txn(1'b1, 1'b0, 3'b010, 32'h00000100, 32'h0, 32'h11223344, 32'h0, 2, 0, 1'b0);
    checks++; if (bus_if.w_dram_odata !== 32'h11223344) begin errors++; $display("FAIL lw_const: got %h exp 11223344", bus_if.w_dram_odata); end
    do_txn(1'b1, 1'b0, 3'b000, 32'h00000103, 32'h0, 32'h80123456, 32'h0, 0, 0, 1'b0);
    checks++; if (bus_if.w_dram_odata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_const: got %h exp ffffff80", bus_if.w_dram_odata); end
    do_txn(1'b1, 1'b0, 3'b100, 32'h00000103, 32'h0, 32'h80123456, 32'h0, 1, 0, 1'b0);
    checks++; if (bus_if.w_dram_odata !== 32'h00000080) begin errors++; $display("FAIL lbu_const: got %h exp 00000080", bus_if.w_dram_odata); end
    do_txn(1'b0, 1'b1, 3'b010, 32'h00000102, 32'hAABBCCDD, 32'h0, 32'h0, 0, 1, 1'b0);
    checks++; if (bus_if.w_dram_odata !== 32'h00000080) begin errors++; $display("FAIL store_keeps_odata: got %h exp 00000080", bus_if.w_dram_odata); end
    do_txn(1'b1, 1'b0, 3'b001, 32'h00000107, 32'h0, 32'h34AABBCC, 32'hDDEEFF12, 0, 2, 1'b0);
    checks++; if (bus_if.w_dram_odata !== 32'h00001234) begin errors++; $display("FAIL lh_split_const: got %h exp 00001234", bus_if.w_dram_odata); end
    do_txn(1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h5566AABB, 32'h11223344, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 1'b1, 3'b010, 32'h00000200, 32'h12345678, 32'h0, 32'h0, 1, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (bus_if.mc_req !== 1'b0 || bus_if.w_dram_busy !== 1'b0) begin errors++; $display("FAIL dropped_le_quiet: req %b busy %b exp 0 0", bus_if.mc_req, bus_if.w_dram_busy); end
    end
  endtask

  task automatic test_random();
    int sel;
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 2);
      do_txn(sel != 1, sel != 0, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_reset_mid_beat();
    @(negedge CLK);
    bus_if.w_dram_addr = 32'h00000306; bus_if.w_dram_ctrl = 3'b010; bus_if.w_dram_le = 1'b1;
    @(negedge CLK);
    bus_if.w_dram_le = 1'b0;
    checks++; if (bus_if.mc_req !== 1'b1) begin errors++; $display("FAIL midrst_req_before: got %b exp 1", bus_if.mc_req); end
    #2 RST_X = 1'b0;
    #1;
    checks++; if (bus_if.mc_req !== 1'b0 || bus_if.w_dram_busy !== 1'b0) begin errors++; $display("FAIL midrst_req_busy: got %b %b exp 0 0", bus_if.mc_req, bus_if.w_dram_busy); end
    checks++; if (bus_if.mc_addr !== 32'h0 || bus_if.mc_be !== 4'b0000 || bus_if.w_dram_odata !== 32'h0) begin errors++; $display("FAIL midrst_outs: got %h %b %h exp 0", bus_if.mc_addr, bus_if.mc_be, bus_if.w_dram_odata); end
    exp_odata = 32'h0;
    @(negedge CLK);
    RST_X = 1'b1;
    @(negedge CLK);
    checks++; if (bus_if.mc_req !== 1'b0) begin errors++; $display("FAIL midrst_after: got %b exp 0", bus_if.mc_req); end
    do_txn(1'b1, 1'b0, 3'b101, 32'h00000402, 32'h0, 32'hF00D1234, 32'h0, 1, 0, 1'b0);
  endtask

`ifdef DRAM_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    @(negedge CLK);
    bus_if.w_dram_addr = 32'h00000040; bus_if.w_dram_ctrl = 3'b010; bus_if.w_dram_le = 1'b1;
    @(negedge CLK);
    bus_if.w_dram_le = 1'b0;
    cnt = 0;
    while (bus_if.mc_req === 1'b1 && cnt < 100) begin cnt++; @(negedge CLK); end
    checks++; if (cnt != TMO) begin errors++; $display("FAIL tmo_len: got %0d exp %0d", cnt, TMO); end
    checks++; if (bus_if.err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b exp 1", bus_if.err_timeout); end
    checks++; if (bus_if.w_dram_odata !== 32'hDEADBEEF) begin errors++; $display("FAIL tmo_odata: got %h exp deadbeef", bus_if.w_dram_odata); end
    checks++; if (bus_if.w_dram_busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b exp 0", bus_if.w_dram_busy); end
    exp_odata = 32'hDEADBEEF;
    @(negedge CLK);
    checks++; if (bus_if.err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse_end: got %b exp 0", bus_if.err_timeout); end
  endtask
`endif

  initial begin
    bus_if.w_dram_addr = 32'h0; bus_if.w_dram_wdata = 32'h0; bus_if.w_dram_ctrl = 3'b000;
    bus_if.w_dram_le = 1'b0; bus_if.w_dram_we_t = 1'b0;
    bus_if.mc_ack = 1'b0; bus_if.mc_rdata = 32'h0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_beat();
`ifdef DRAM_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
